// File: rtl/rx_frame_front_pkg.sv
// Shared constants and types for the receive frame front end (preamble/SFD
// stripping, FCS removal, CRC check, segment-id extraction, statistics).
package rx_frame_front_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int          MIN_FRAME     = 64;
    // Bytes held back so the trailing FCS is never forwarded.
    localparam int          DELAY_BYTES   = 4;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP
    } state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 update, one byte per call, reflected (LSB-first) form.
module crc32_d8
    import rx_frame_front_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_work;

    always_comb begin
        crc_work = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_work[0] ^ data[i]) begin
                crc_work = (crc_work >> 1) ^ CRC_POLY;
            end else begin
                crc_work = crc_work >> 1;
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/rx_frame_front.sv
// Receive front end: strips preamble/SFD/FCS, extracts a segment id and keeps
// frame statistics. Define RX_CRC_CHECK_EN to build and enforce the CRC check.
module rx_frame_front
    import rx_frame_front_pkg::*;
#(
    parameter int ID_OFFSET = 25,
    parameter int ID_WIDTH  = 16,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk125MHz,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_enable,
    input  logic                 rx_error,
    output logic [7:0]           data_out,
    output logic                 en_out,
    output logic                 sof_out,
    output logic                 eof_out,
    output logic                 frame_ok,
    output logic [ID_WIDTH-1:0]  seg_out,
    output logic                 seg_valid,
    output logic [CNT_WIDTH-1:0] cnt_good,
    output logic [CNT_WIDTH-1:0] cnt_crc_err,
    output logic [CNT_WIDTH-1:0] cnt_runt,
    output logic [CNT_WIDTH-1:0] cnt_long,
    output logic [CNT_WIDTH-1:0] cnt_phy_err
);

    localparam int ID_BYTES = ID_WIDTH / 8;
    localparam int LEN_W    = $clog2(MAX_FRAME + 2);

    localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_FRAME + 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_FRAME);
    localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] LEN_DLY   = LEN_W'(DELAY_BYTES);
    localparam logic [LEN_W-1:0] SEG_FIRST = LEN_W'(ID_OFFSET);
    localparam logic [LEN_W-1:0] SEG_LAST  = LEN_W'(ID_OFFSET + ID_BYTES - 1);

    state_t             state_reg, state_next;
    logic               hold_drop_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               phy_err_reg;
    logic [7:0]         dl_reg [DELAY_BYTES];

    logic               accept;
    logic               frame_end;
    logic               sfd_seen;
    logic               seg_take;
    logic [ID_WIDTH-1:0] seg_word;
    logic               crc_good;
    logic               is_runt, is_long, frame_good;
    logic               hit_phy, hit_runt, hit_long, hit_good;

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        frame_end  = 1'b0;
        sfd_seen   = 1'b0;
        case (state_reg)
            IDLE: begin
                // A frame already in flight when reset was released is not trusted.
                if (rx_enable) begin
                    state_next = hold_drop_reg ? DROP : PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (!rx_enable) begin
                    state_next = IDLE;
                end else if (rx_data == SFD_BYTE) begin
                    state_next = PAYLOAD;
                    sfd_seen   = 1'b1;
                end else if (rx_data != PREAMBLE_BYTE) begin
                    state_next = DROP;
                end
            end
            PAYLOAD: begin
                if (!rx_enable) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    accept = 1'b1;
                end
            end
            DROP: begin
                if (!rx_enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign seg_take   = accept && (len_reg >= SEG_FIRST) && (len_reg <= SEG_LAST);
    assign is_runt    = len_reg < LEN_MIN;
    assign is_long    = len_reg > LEN_MAX;
    assign frame_good = crc_good && !is_runt && !is_long && !phy_err_reg;
    assign hit_phy    = frame_end && phy_err_reg;
    assign hit_runt   = frame_end && !phy_err_reg && is_runt;
    assign hit_long   = frame_end && !phy_err_reg && !is_runt && is_long;
    assign hit_good   = frame_end && frame_good;

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            hold_drop_reg <= 1'b1;
        end else if (!rx_enable) begin
            hold_drop_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            len_reg     <= '0;
            phy_err_reg <= 1'b0;
            data_out    <= '0;
            en_out      <= 1'b0;
            sof_out     <= 1'b0;
            eof_out     <= 1'b0;
            frame_ok    <= 1'b0;
            seg_out     <= '0;
            seg_valid   <= 1'b0;
            for (int i = 0; i < DELAY_BYTES; i++) begin
                dl_reg[i] <= '0;
            end
        end else begin
            en_out    <= 1'b0;
            sof_out   <= 1'b0;
            eof_out   <= 1'b0;
            frame_ok  <= 1'b0;
            seg_valid <= 1'b0;
            if (sfd_seen) begin
                len_reg     <= '0;
                phy_err_reg <= 1'b0;
            end
            if (accept) begin
                dl_reg[0] <= rx_data;
                for (int i = 1; i < DELAY_BYTES; i++) begin
                    dl_reg[i] <= dl_reg[i-1];
                end
                if (len_reg != LEN_SAT) begin
                    len_reg <= len_reg + LEN_W'(1);
                end
                if (rx_error) begin
                    phy_err_reg <= 1'b1;
                end
                // Oldest byte leaves the delay line; oversize frames are truncated.
                if ((len_reg >= LEN_DLY) && (len_reg < LEN_MAX)) begin
                    data_out <= dl_reg[DELAY_BYTES-1];
                    en_out   <= 1'b1;
                    sof_out  <= (len_reg == LEN_DLY);
                end
                if (seg_take && (len_reg == SEG_LAST)) begin
                    seg_out   <= seg_word;
                    seg_valid <= 1'b1;
                end
            end
            if (frame_end) begin
                eof_out  <= 1'b1;
                frame_ok <= frame_good;
                len_reg  <= '0;
                for (int i = 0; i < DELAY_BYTES; i++) begin
                    dl_reg[i] <= '0;
                end
            end
        end
    end

    generate
        if (ID_BYTES > 1) begin : g_seg_wide
            logic [ID_WIDTH-9:0] seg_hold_reg;
            always_ff @(posedge clk125MHz) begin
                if (rst) begin
                    seg_hold_reg <= '0;
                end else if (seg_take) begin
                    seg_hold_reg <= seg_word[ID_WIDTH-9:0];
                end
            end
            assign seg_word = {seg_hold_reg, rx_data};
        end else begin : g_seg_byte
            assign seg_word = rx_data;
        end
    endgenerate

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            cnt_good    <= '0;
            cnt_runt    <= '0;
            cnt_long    <= '0;
            cnt_phy_err <= '0;
        end else begin
            if (hit_good && (cnt_good != '1)) begin
                cnt_good <= cnt_good + CNT_WIDTH'(1);
            end
            if (hit_runt && (cnt_runt != '1)) begin
                cnt_runt <= cnt_runt + CNT_WIDTH'(1);
            end
            if (hit_long && (cnt_long != '1)) begin
                cnt_long <= cnt_long + CNT_WIDTH'(1);
            end
            if (hit_phy && (cnt_phy_err != '1)) begin
                cnt_phy_err <= cnt_phy_err + CNT_WIDTH'(1);
            end
        end
    end

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc_reg;
    logic [31:0] crc_upd;
    logic        hit_crc;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_reg),
        .data    (rx_data),
        .crc_out (crc_upd)
    );

    // Running over the FCS too leaves the fixed residue on an intact frame.
    assign crc_good = (crc_reg == CRC_RESIDUE);
    assign hit_crc  = frame_end && !phy_err_reg && !is_runt && !is_long && !crc_good;

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            crc_reg     <= '0;
            cnt_crc_err <= '0;
        end else begin
            if (sfd_seen) begin
                crc_reg <= CRC_INIT;
            end else if (accept) begin
                crc_reg <= crc_upd;
            end
            if (hit_crc && (cnt_crc_err != '1)) begin
                cnt_crc_err <= cnt_crc_err + CNT_WIDTH'(1);
            end
        end
    end
`else
    assign crc_good    = 1'b1;
    assign cnt_crc_err = '0;
`endif

endmodule

// File: tb/tb_rx_frame_front.sv
// Self-checking bench for rx_frame_front: table vectors, hand-written
// back-to-back/reset sequences and randomized frames against a frame-level model.
module tb_rx_frame_front;

    localparam int ID_OFFSET = 25;
    localparam int ID_WIDTH  = 16;
    localparam int MAX_FRAME = 1518;
    localparam int CNT_WIDTH = 32;

`ifdef RX_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    localparam int C_NONE = 0;
    localparam int C_GOOD = 1;
    localparam int C_CRC  = 2;
    localparam int C_RUNT = 3;
    localparam int C_LONG = 4;
    localparam int C_PHY  = 5;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        int len;
        bit flip;
        int err_at;
        int bad_pos;
        bit put_seg;
        int cls;
        int fwd;
        bit seg;
    } vec_t;

    logic                 clk125MHz;
    logic                 rst;
    logic [7:0]           rx_data;
    logic                 rx_enable;
    logic                 rx_error;
    logic [7:0]           data_out;
    logic                 en_out;
    logic                 sof_out;
    logic                 eof_out;
    logic                 frame_ok;
    logic [ID_WIDTH-1:0]  seg_out;
    logic                 seg_valid;
    logic [CNT_WIDTH-1:0] cnt_good, cnt_crc_err, cnt_runt, cnt_long, cnt_phy_err;

    rx_frame_front #(
        .ID_OFFSET (ID_OFFSET),
        .ID_WIDTH  (ID_WIDTH),
        .MAX_FRAME (MAX_FRAME),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk125MHz   (clk125MHz),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_enable   (rx_enable),
        .rx_error    (rx_error),
        .data_out    (data_out),
        .en_out      (en_out),
        .sof_out     (sof_out),
        .eof_out     (eof_out),
        .frame_ok    (frame_ok),
        .seg_out     (seg_out),
        .seg_valid   (seg_valid),
        .cnt_good    (cnt_good),
        .cnt_crc_err (cnt_crc_err),
        .cnt_runt    (cnt_runt),
        .cnt_long    (cnt_long),
        .cnt_phy_err (cnt_phy_err)
    );

    initial clk125MHz = 1'b0;
    always #4 clk125MHz = ~clk125MHz;

    int n_checks = 0;
    int n_errors = 0;

    bq_t           got;
    int            eof_cnt, sof_cnt, sof_bad, seg_cnt;
    logic          last_ok;
    logic [15:0]   last_seg;
    longint        exp_cnt [5];

    always @(negedge clk125MHz) begin
        if (en_out) got.push_back(data_out);
        if (sof_out) begin
            sof_cnt++;
            if (!en_out || got.size() != 1) sof_bad++;
        end
        if (eof_out) begin
            eof_cnt++;
            last_ok = frame_ok;
        end
        if (seg_valid) begin
            seg_cnt++;
            last_seg = seg_out;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        got.delete();
        eof_cnt = 0;
        sof_cnt = 0;
        sof_bad = 0;
        seg_cnt = 0;
    endtask

    function automatic logic [31:0] crc_std(input bq_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t make_body(input int len, input bit flip, input bit put_seg);
        bq_t b;
        logic [31:0] c;
        if (len < 4) begin
            for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
            return b;
        end
        for (int i = 0; i < len - 4; i++) b.push_back(8'($urandom_range(0, 255)));
        if (put_seg && (len - 4 > ID_OFFSET + 1)) begin
            b[ID_OFFSET]     = 8'h12;
            b[ID_OFFSET + 1] = 8'h34;
        end
        c = crc_std(b, len - 4);
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
        b.push_back(c[23:16]);
        b.push_back(c[31:24]);
        if (flip) b[0] = b[0] ^ 8'h01;
        return b;
    endfunction

    function automatic bq_t make_stream(input bq_t body, input int bad_pos);
        bq_t s;
        for (int i = 0; i < 7; i++) s.push_back((i == bad_pos) ? 8'h57 : 8'h55);
        s.push_back(8'hD5);
        foreach (body[i]) s.push_back(body[i]);
        return s;
    endfunction

    // Frame-level expectation: FCS compared as a plain CRC of the payload.
    function automatic void model(input bq_t b, input int err_at,
                                  output int cls, output int fwd, output bit seg);
        int L;
        bit crc_ok;
        L = b.size();
        crc_ok = 1'b1;
        if (CRC_ON) begin
            if (L < 4) crc_ok = 1'b0;
            else crc_ok = (crc_std(b, L - 4) == {b[L-1], b[L-2], b[L-3], b[L-4]});
        end
        fwd = (L > MAX_FRAME) ? MAX_FRAME - 4 : ((L > 4) ? L - 4 : 0);
        seg = (L >= ID_OFFSET + ID_WIDTH / 8);
        if (err_at >= 0 && err_at < L) cls = C_PHY;
        else if (L < 64)               cls = C_RUNT;
        else if (L > MAX_FRAME)        cls = C_LONG;
        else if (!crc_ok)              cls = C_CRC;
        else                           cls = C_GOOD;
    endfunction

    task automatic send_raw(input bq_t s, input int err_at, input int rst_at, input int gap);
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk125MHz); #1;
            if (rst_at >= 0 && i == rst_at + 1) clear_mon();
            rst       = (i == rst_at);
            rx_enable = 1'b1;
            rx_data   = s[i];
            rx_error  = (i == err_at);
        end
        @(posedge clk125MHz); #1;
        rst       = 1'b0;
        rx_enable = 1'b0;
        rx_error  = 1'b0;
        rx_data   = 8'h00;
        for (int g = 1; g < gap; g++) begin
            @(posedge clk125MHz); #1;
        end
    endtask

    task automatic check_counters(input string tag);
        chk({tag, ":cnt_good"},    longint'(cnt_good),    exp_cnt[0]);
        chk({tag, ":cnt_crc_err"}, longint'(cnt_crc_err), exp_cnt[1]);
        chk({tag, ":cnt_runt"},    longint'(cnt_runt),    exp_cnt[2]);
        chk({tag, ":cnt_long"},    longint'(cnt_long),    exp_cnt[3]);
        chk({tag, ":cnt_phy_err"}, longint'(cnt_phy_err), exp_cnt[4]);
    endtask

    task automatic check_frame(input string tag, input bq_t body, input int cls,
                               input int fwd, input bit seg_exp);
        int mism;
        logic [15:0] segv;
        repeat (4) @(posedge clk125MHz);
        #1;
        chk({tag, ":eof"}, eof_cnt, (cls != C_NONE) ? 1 : 0);
        if (cls != C_NONE) chk({tag, ":frame_ok"}, longint'(last_ok), (cls == C_GOOD) ? 1 : 0);
        chk({tag, ":fwd_len"}, got.size(), fwd);
        mism = 0;
        for (int i = 0; i < got.size() && i < body.size(); i++) if (got[i] !== body[i]) mism++;
        chk({tag, ":data"}, mism, 0);
        chk({tag, ":sof"}, (sof_bad == 0) ? sof_cnt : -1, (fwd > 0) ? 1 : 0);
        chk({tag, ":seg_valid"}, seg_cnt, seg_exp ? 1 : 0);
        if (seg_exp) begin
            segv = {body[ID_OFFSET], body[ID_OFFSET + 1]};
            chk({tag, ":seg_out"}, longint'(last_seg), longint'(segv));
        end
        if (cls != C_NONE) exp_cnt[cls - 1]++;
        check_counters(tag);
        $display("%s len=%0d class=%0d fwd=%0d eof=%0d ok=%0d seg=%0d", tag, body.size(),
                 cls, got.size(), eof_cnt, last_ok, seg_cnt);
        clear_mon();
    endtask

    vec_t tbl [14];

    initial begin
        bq_t body, b2;
        int  cls, fwd, err_at, len, mism;
        bit  seg;

        tbl[0]  = '{64,   1'b0, -1, -1, 1'b0, C_GOOD, 60,   1'b1};
        tbl[1]  = '{64,   1'b1, -1, -1, 1'b0, C_CRC,  60,   1'b1};
        tbl[2]  = '{64,   1'b0, -1, -1, 1'b1, C_GOOD, 60,   1'b1};
        tbl[3]  = '{20,   1'b0, -1, -1, 1'b0, C_RUNT, 16,   1'b0};
        tbl[4]  = '{64,   1'b0, -1,  3, 1'b0, C_NONE, 0,    1'b0};
        tbl[5]  = '{64,   1'b0, -1, -1, 1'b0, C_GOOD, 60,   1'b1};
        tbl[6]  = '{1600, 1'b0, -1, -1, 1'b0, C_LONG, 1514, 1'b1};
        tbl[7]  = '{64,   1'b0, 10, -1, 1'b0, C_PHY,  60,   1'b1};
        tbl[8]  = '{1518, 1'b0, -1, -1, 1'b0, C_GOOD, 1514, 1'b1};
        tbl[9]  = '{1519, 1'b0, -1, -1, 1'b0, C_LONG, 1514, 1'b1};
        tbl[10] = '{63,   1'b0, -1, -1, 1'b0, C_RUNT, 59,   1'b1};
        tbl[11] = '{27,   1'b0, -1, -1, 1'b0, C_RUNT, 23,   1'b1};
        tbl[12] = '{26,   1'b0, -1, -1, 1'b0, C_RUNT, 22,   1'b0};
        tbl[13] = '{3,    1'b0, -1, -1, 1'b0, C_RUNT, 0,    1'b0};

        for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
        rst = 1'b1; rx_enable = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk125MHz);
        #1;
        chk("reset:data_out", data_out, 0);
        chk("reset:en_out", en_out, 0);
        chk("reset:sof_out", sof_out, 0);
        chk("reset:eof_out", eof_out, 0);
        chk("reset:frame_ok", frame_ok, 0);
        chk("reset:seg_out", seg_out, 0);
        chk("reset:seg_valid", seg_valid, 0);
        check_counters("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk125MHz);
        #1;
        clear_mon();

        for (int t = 0; t < 14; t++) begin
            body = make_body(tbl[t].len, tbl[t].flip, tbl[t].put_seg);
            cls  = tbl[t].cls;
            if (cls == C_CRC && !CRC_ON) cls = C_GOOD;
            send_raw(make_stream(body, tbl[t].bad_pos),
                     (tbl[t].err_at >= 0) ? tbl[t].err_at + 8 : -1, -1, 1);
            check_frame($sformatf("vec%0d", t), body, cls, tbl[t].fwd, tbl[t].seg);
        end

        // Two good frames separated by a single idle cycle.
        body = make_body(64, 1'b0, 1'b0);
        b2   = make_body(64, 1'b0, 1'b0);
        send_raw(make_stream(body, -1), -1, -1, 1);
        send_raw(make_stream(b2, -1), -1, -1, 1);
        repeat (4) @(posedge clk125MHz);
        #1;
        chk("b2b:eof", eof_cnt, 2);
        chk("b2b:frame_ok", longint'(last_ok), 1);
        chk("b2b:fwd_len", got.size(), 120);
        mism = 0;
        for (int i = 0; i < got.size() && i < 120; i++)
            if (got[i] !== ((i < 60) ? body[i] : b2[i - 60])) mism++;
        chk("b2b:data", mism, 0);
        exp_cnt[0] += 2;
        check_counters("b2b");
        $display("b2b frames=2 fwd=%0d eof=%0d", got.size(), eof_cnt);
        clear_mon();

        // Reset at payload byte 30, then a good frame one idle cycle later.
        body = make_body(80, 1'b0, 1'b0);
        b2   = make_body(64, 1'b0, 1'b0);
        send_raw(make_stream(body, -1), -1, 8 + 30, 1);
        for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
        chk("rst_mid:eof", eof_cnt, 0);
        check_counters("rst_mid");
        send_raw(make_stream(b2, -1), -1, -1, 1);
        check_frame("rst_next", b2, C_GOOD, 60, 1'b1);

        for (int r = 0; r < 25; r++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1510, 1530))
                                              : int'($urandom_range(1, 100));
            body   = make_body(len, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            err_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            model(body, err_at, cls, fwd, seg);
            send_raw(make_stream(body, -1), (err_at >= 0) ? err_at + 8 : -1, -1,
                     int'($urandom_range(1, 3)));
            check_frame($sformatf("rnd%0d", r), body, cls, fwd, seg);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
